// File: rtl/sfp_tx_arbiter.sv
// Two-source arbiter for the 64-bit SFP TX word interface: buffered video (priority) plus aux.
// Optional idle-word insertion is enabled by defining SFP_IDLE_FILL_EN.
module sfp_tx_arbiter #(
  parameter int unsigned VID_FIFO_DEPTH = 16,
  parameter int unsigned MAX_VID_BURST  = 8,
  parameter logic [7:0]  NODE_INFO      = 8'h12,
  parameter int unsigned IDLE_GAP       = 64
) (
  input  logic                              sfp_clk_in,
  input  logic                              rst,
  input  logic                              vid_valid,
  input  logic [63:0]                       vid_data,
  input  logic                              aux_valid,
  input  logic [63:0]                       aux_data,
  output logic                              aux_ready,
  output logic                              tx_valid,
  output logic [63:0]                       tx_data,
  input  logic                              tx_ready,
  input  logic                              ovf_clr,
  output logic                              ovf_flag,
  output logic [15:0]                       drop_cnt,
  output logic [$clog2(VID_FIFO_DEPTH):0]   vid_level
);

  localparam int unsigned AW = $clog2(VID_FIFO_DEPTH);

  localparam logic [AW:0]   FULL_LVL = VID_FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [7:0]    MAX_RUN  = MAX_VID_BURST[7:0];
  localparam logic [63:0]   IDLE_WORD = {48'h000000000000, 2'b00, 6'd0, NODE_INFO};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_VID  = 2'd1;
  localparam logic [1:0] ST_AUX  = 2'd2;
  localparam logic [1:0] ST_FILL = 2'd3;

  logic [63:0]   fifo_mem [VID_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          fifo_empty, fifo_full;

  logic [1:0]    state_q, state_d;
  logic [63:0]   tx_data_q, tx_data_d;
  logic [7:0]    vid_run_q;
  logic          ovf_flag_q;
  logic [15:0]   drop_cnt_q;

  logic load_en, aux_sel, vid_sel, idle_sel;
  logic aux_load, vid_load, push, drop;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == FULL_LVL);

  // tx_valid is encoded in the state: any non-IDLE state holds a word.
  assign tx_valid = (state_q != ST_IDLE);
  assign load_en  = !tx_valid | tx_ready;

  assign aux_sel  = aux_valid & (fifo_empty | (vid_run_q >= MAX_RUN));
  assign vid_sel  = !fifo_empty & !aux_sel;
  assign aux_load = load_en & aux_sel;
  assign vid_load = load_en & vid_sel;
  assign aux_ready = aux_load;

  assign push = vid_valid & (!fifo_full | vid_load);
  assign drop = vid_valid & !push;

`ifdef SFP_IDLE_FILL_EN
  logic [15:0] idle_cnt_q;

  assign idle_sel = load_en & !aux_sel & !vid_sel & (idle_cnt_q == IDLE_GAP[15:0]);

  always_ff @(posedge sfp_clk_in) begin
    if (rst) begin
      idle_cnt_q <= 16'd0;
    end else if (aux_load | vid_load | idle_sel) begin
      idle_cnt_q <= 16'd0;
    end else if ((state_q == ST_IDLE) && !tx_valid) begin
      idle_cnt_q <= idle_cnt_q + 16'd1;
    end
  end
`else
  assign idle_sel = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    if (load_en) begin
      if (aux_sel) begin
        state_d   = ST_AUX;
        tx_data_d = aux_data;
      end else if (vid_sel) begin
        state_d   = ST_VID;
        tx_data_d = fifo_mem[rd_ptr_q];
      end else if (idle_sel) begin
        state_d   = ST_FILL;
        tx_data_d = IDLE_WORD;
      end else begin
        state_d   = ST_IDLE;
      end
    end
  end

  always_ff @(posedge sfp_clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= vid_data;
    end
  end

  always_ff @(posedge sfp_clk_in) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push)     wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (vid_load) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push && !vid_load)      level_q <= level_q + LVL_ONE;
      else if (!push && vid_load) level_q <= level_q - LVL_ONE;
    end
  end

  always_ff @(posedge sfp_clk_in) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_data_q <= 64'd0;
      vid_run_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      // The burst counter only runs while aux is actually waiting.
      if (aux_load) begin
        vid_run_q <= 8'd0;
      end else if (vid_load) begin
        if (!aux_valid)               vid_run_q <= 8'd0;
        else if (vid_run_q != 8'hFF)  vid_run_q <= vid_run_q + 8'd1;
      end
    end
  end

  always_ff @(posedge sfp_clk_in) begin
    if (rst || ovf_clr) begin
      ovf_flag_q <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else if (drop) begin
      ovf_flag_q <= 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign tx_data   = tx_data_q;
  assign ovf_flag  = ovf_flag_q;
  assign drop_cnt  = drop_cnt_q;
  assign vid_level = level_q;

endmodule

// File: tb/tb_sfp_tx_arbiter.sv
// Randomised and directed bench for sfp_tx_arbiter against a queue-based reference model.
module tb_sfp_tx_arbiter;

  localparam int DEPTH = 16;
  localparam int MAXB  = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, vid_valid, aux_valid, tx_ready, ovf_clr;
  logic [63:0]   vid_data, aux_data;
  logic          aux_ready, tx_valid, ovf_flag;
  logic [63:0]   tx_data;
  logic [15:0]   drop_cnt;
  logic [LW-1:0] vid_level;

  always #5 clk = ~clk;

  sfp_tx_arbiter #(
    .VID_FIFO_DEPTH (DEPTH),
    .MAX_VID_BURST  (MAXB),
    .NODE_INFO      (8'h12),
    .IDLE_GAP       (64)
  ) dut (
    .sfp_clk_in (clk),
    .rst        (rst),
    .vid_valid  (vid_valid),
    .vid_data   (vid_data),
    .aux_valid  (aux_valid),
    .aux_data   (aux_data),
    .aux_ready  (aux_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .ovf_clr    (ovf_clr),
    .ovf_flag   (ovf_flag),
    .drop_cnt   (drop_cnt),
    .vid_level  (vid_level)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue for the FIFO plus the held output word.
  logic [63:0] q[$];
  bit          m_valid = 0;
  logic [63:0] m_data = '0;
  int          m_run = 0;
  bit          m_ovf = 0;
  int          m_drop = 0;
  bit          started = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_valid = 0; m_data = '0; m_run = 0; m_ovf = 0; m_drop = 0;
      started = 1;
    end else begin
      bit le, em, fl, asel, vsel, pop, dropped;
      le = !m_valid || tx_ready;
      em = (q.size() == 0);
      fl = (q.size() == DEPTH);
      asel = aux_valid && (em || m_run >= MAXB);
      vsel = !em && !asel;
      pop = le && vsel;
      dropped = 0;
      if (le) begin
        if (asel) begin
          m_data = aux_data; m_valid = 1; m_run = 0;
        end else if (vsel) begin
          m_data = q.pop_front(); m_valid = 1;
          m_run = aux_valid ? ((m_run < 255) ? m_run + 1 : 255) : 0;
        end else begin
          m_valid = 0;
        end
      end
      if (vid_valid) begin
        if (!fl || pop) q.push_back(vid_data);
        else dropped = 1;
      end
      if (ovf_clr) begin
        m_ovf = 0; m_drop = 0;
      end else if (dropped) begin
        m_ovf = 1;
        if (m_drop < 16'hFFFF) m_drop++;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit le, asel;
      le = !m_valid || tx_ready;
      asel = aux_valid && (q.size() == 0 || m_run >= MAXB);
      chk("tx_valid", tx_valid, m_valid);
      if (m_valid) chk("tx_data", tx_data, m_data);
      chk("aux_ready", aux_ready, le && asel);
      chk("ovf_flag", ovf_flag, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("vid_level", vid_level, q.size());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int cnt;

  initial begin
    rst = 1; vid_valid = 0; aux_valid = 0; tx_ready = 0; ovf_clr = 0;
    vid_data = '0; aux_data = '0;
    repeat (2) step();
    rst = 0;
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_level", vid_level, 0);
    chk("rst_drop", drop_cnt, 0);

    // Single video word: visible one cycle after its push edge, then gone.
    step();
    tx_ready = 1; vid_valid = 1; vid_data = 64'hAABBCCDDEEFF8012;
    step();
    vid_valid = 0;
    step();
    @(negedge clk);
    chk("t1_valid", tx_valid, 1);
    chk("t1_data", tx_data, 64'hAABBCCDDEEFF8012);
    step();
    @(negedge clk);
    chk("t1_fall", tx_valid, 0);

    // Continuous video with aux pending: aux wins at edges 1, 10, 19, 28.
    step();
    aux_valid = 1; vid_valid = 1; cnt = 0;
    for (int i = 0; i < 36; i++) begin
      vid_data = {$urandom, $urandom};
      aux_data = {32'hA0A0_0000, 32'(i)};
      @(negedge clk);
      if (aux_ready) cnt++;
      step();
    end
    @(negedge clk);
    chk("t2_aux_slots", cnt, 4);
    chk("t2_level", vid_level, 4);
    step();
    aux_valid = 0; vid_valid = 0;
    repeat (12) step();

    // Stall output with an aux word, then overfill the FIFO.
    tx_ready = 0; aux_valid = 1; aux_data = 64'h0123456789ABC0C3;
    step();
    aux_valid = 0;
    for (int i = 0; i < 20; i++) begin
      vid_valid = 1; vid_data = {48'hBEEF00 + 48'(i), 16'h4012};
      step();
    end
    vid_valid = 0;
    @(negedge clk);
    chk("t3_level", vid_level, 16);
    chk("t3_drop", drop_cnt, 4);
    chk("t3_ovf", ovf_flag, 1);
    step();
    for (int i = 0; i < 6; i++) begin
      aux_valid = i[0]; aux_data = {$urandom, $urandom};
      @(negedge clk);
      chk("t4_hold", tx_data, 64'h0123456789ABC0C3);
      chk("t4_aux_ready", aux_ready, 0);
      step();
    end
    aux_valid = 0; ovf_clr = 1;
    step();
    ovf_clr = 0;
    @(negedge clk);
    chk("t4_clr_drop", drop_cnt, 0);
    chk("t4_clr_ovf", ovf_flag, 0);
    step();
    tx_ready = 1;
    step();
    @(negedge clk);
    chk("t3_first_drain", tx_data, {48'hBEEF00, 16'h4012});
    repeat (20) step();

    // Reset while busy.
    tx_ready = 0; aux_valid = 1; aux_data = 64'h5555;
    step();
    aux_valid = 0;
    for (int i = 0; i < 5; i++) begin
      vid_valid = 1; vid_data = 64'h77 + 64'(i);
      step();
    end
    vid_valid = 0;
    @(negedge clk);
    chk("t5_pre_level", vid_level, 5);
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("t5_valid", tx_valid, 0);
    chk("t5_level", vid_level, 0);
    step();
    tx_ready = 1; vid_valid = 1; vid_data = 64'hCAFE000000004012;
    step();
    vid_valid = 0;
    @(negedge clk);
    chk("t5_not_yet", tx_valid, 0);
    step();
    @(negedge clk);
    chk("t5_valid_post", tx_valid, 1);
    chk("t5_data_post", tx_data, 64'hCAFE000000004012);
    step();

    // Random traffic with alternating backpressure regimes.
    for (int i = 0; i < 3000; i++) begin
      vid_valid = ($urandom % 10) < 6;
      vid_data  = {$urandom, $urandom};
      aux_valid = ($urandom % 3) == 0;
      aux_data  = {$urandom, $urandom};
      tx_ready  = ((i / 300) % 2 == 0) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
      ovf_clr   = ($urandom % 100) == 0;
      rst       = ($urandom % 500) == 0;
      step();
    end
    rst = 0; vid_valid = 0; aux_valid = 0; ovf_clr = 0; tx_ready = 1;

`ifndef SFP_IDLE_FILL_EN
    rst = 1;
    step();
    rst = 0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_valid) cnt++;
      step();
    end
    chk("t6_no_idle", cnt, 0);
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
